// File: rtl/trig_capture.sv
// trig_capture: ring-buffer ADC capture around a trigger edge, then UART byte readout.
// Ports: clk, rst_n, adc_in[13:0], trig_in, arm -> tx_data[7:0]/tx_valid/tx_ready, busy, done.
module trig_capture #(
  parameter int DEPTH = 256,
  parameter int PRE   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] adc_in,
  input  logic        trig_in,
  input  logic        arm,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int BW     = AW + 2;
  localparam int POST_N = DEPTH - PRE;

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_N - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
  localparam logic [BW-1:0] LAST_B    = BW'(2 * DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    READOUT
  } state_t;

  state_t state, state_nx;

  logic [13:0]   mem [DEPTH];
  logic [13:0]   rd_data;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic          trig_q;
  logic          trig_ev;
  logic          wr_en;
  logic          rd_en;
  logic          xfer;
  logic          last_b;

  assign trig_ev = trig_in & ~trig_q;
  assign xfer    = tx_valid & tx_ready;
  assign last_b  = (bcnt == LAST_B);
  assign busy    = (state != IDLE);
  assign done    = (state == READOUT) & xfer & last_b;
  assign wr_en   = (state == PREFILL) | (state == WAIT_TRIG) | (state == POST);

  // bcnt counts bytes loaded into tx_data. A sample is fetched one byte
  // ahead: at READOUT entry, and again whenever a low byte is loaded, so
  // the next high byte finds rd_data already valid.
  assign rd_en = (state == READOUT) &
                 ((bcnt == '0) | (xfer & ~last_b & ~bcnt[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (arm) state_nx = PREFILL;
      PREFILL:   if (cnt == PRE_LAST) state_nx = WAIT_TRIG;
      WAIT_TRIG: if (trig_ev) state_nx = (POST_N == 1) ? READOUT : POST;
      POST:      if (cnt == POST_LAST) state_nx = READOUT;
      READOUT:   if (xfer && last_b) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rd_addr  <= '0;
      cnt      <= '0;
      bcnt     <= '0;
      trig_q   <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      trig_q <= trig_in;
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rd_addr <= rd_addr + 1'b1;
      case (state)
        IDLE: begin
          if (arm) begin
            cnt  <= '0;
            bcnt <= '0;
          end
        end
        PREFILL: begin
          cnt <= (cnt == PRE_LAST) ? '0 : cnt + 1'b1;
        end
        WAIT_TRIG: begin
          // trigger sample is counted as the first post sample
          if (trig_ev) begin
            cnt     <= CW'(1);
            rd_addr <= wptr - PRE_OFS;
          end
        end
        POST: begin
          cnt <= cnt + 1'b1;
        end
        READOUT: begin
          if (bcnt == '0) begin
            tx_data  <= 8'hA5;
            tx_valid <= 1'b1;
            bcnt     <= BW'(1);
          end else if (xfer) begin
            if (last_b) begin
              tx_valid <= 1'b0;
            end else begin
              bcnt    <= bcnt + 1'b1;
              tx_data <= bcnt[0] ? {2'b00, rd_data[13:8]}
                                 : rd_data[7:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= adc_in;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_trig_capture.sv
// tb_trig_capture: table-driven and randomized capture scenarios for trig_capture.
// DEPTH=16, PRE=4; expected records come from a sample-list model of the capture rules.
module tb_trig_capture;

  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int NB    = 1 + 2 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] adc_in;
  logic        trig_in;
  logic        arm;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  trig_capture #(.DEPTH(DEPTH), .PRE(PRE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .adc_in(adc_in),
    .trig_in(trig_in),
    .arm(arm),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          d;
    int          rdy;
    bit          rnd;
    int          pf;
    int          pt;
    bit          pp;
    bit          ax;
    bit          frc;
    logic [13:0] tv;
    logic [7:0]  eh;
    logic [7:0]  el;
  } row_t;

  row_t       rows [7];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] act [$];
  logic [7:0] exp_q [$];
  logic [7:0] ref0 [$];

  task automatic check(input string nm, input bit ok,
                       input int got, input int want);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  // One capture: arm in local cycle 0, PRE prefill writes in cycles 1..PRE,
  // trig_in rises d cycles after prefill ends and stays high 3 cycles.
  task automatic run_capture(input int d, input int rdy, input bit rnd,
                             input int pf, input int pt, input bit pp,
                             input bit ax, input bit frc,
                             input logic [13:0] tv, input int abort_at);
    logic [13:0] w [$];
    logic [7:0]  pd;
    int rise, nw, tidx, lastw, fv, dc, ndone, bad, ga, ge;
    int v_busy, v_early, v_stall, v_done;
    bit writing, tprev, pv, pr, fin;
    rise = PRE + 1 + d;
    nw = 0; tidx = -1; lastw = -1; fv = -1; dc = -1; ndone = 0;
    v_busy = 0; v_early = 0; v_stall = 0; v_done = 0;
    writing = 0; tprev = 0; pv = 0; pr = 0; fin = 0; pd = '0;
    act.delete();
    exp_q.delete();
    for (int c = 0; c < 1500 && !fin; c++) begin
      @(negedge clk);
      arm = (c == 0) || (ax && c == rise + 4);
      trig_in = (pf > 0 && c >= pf && c <= pt) ||
                (c >= rise && c < rise + 3) ||
                (pp && c >= rise + 5 && c < rise + 7);
      adc_in = rnd ? 14'($urandom) : 14'(c);
      if (frc && c == rise) adc_in = tv;
      tx_ready = (rdy >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy);
      #1;
      if (writing) begin
        if (nw >= PRE && tidx < 0 && trig_in && !tprev) tidx = nw;
        w.push_back(adc_in);
        nw++;
        if (tidx >= 0 && nw == tidx + DEPTH - PRE) begin
          writing = 0;
          lastw = c;
          exp_q.push_back(8'hA5);
          for (int i = tidx - PRE; i < tidx + DEPTH - PRE; i++) begin
            exp_q.push_back({2'b00, w[i][13:8]});
            exp_q.push_back(w[i][7:0]);
          end
        end
      end
      if (c == 0) writing = 1;
      tprev = trig_in;
      if (busy !== (c > 0)) v_busy++;
      if (tx_valid && !(lastw >= 0 && c > lastw)) v_early++;
      if (pv && !pr && (!tx_valid || tx_data !== pd)) v_stall++;
      if (tx_valid && fv < 0) fv = c;
      if (tx_valid && tx_ready) act.push_back(tx_data);
      if (done) begin
        ndone++;
        dc = c;
        if (!(tx_valid && tx_ready && act.size() == NB)) v_done++;
        fin = 1;
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
      if (abort_at > 0 && act.size() >= abort_at) return;
    end
    check("timeout", fin, int'(fin), 1);
    check("byte_count", act.size() == NB, act.size(), NB);
    bad = -1; ga = 0; ge = 0;
    for (int i = 0; i < NB; i++) begin
      if (i >= act.size() || i >= exp_q.size() || act[i] !== exp_q[i]) begin
        bad = i;
        ga = (i < act.size()) ? int'(act[i]) : -1;
        ge = (i < exp_q.size()) ? int'(exp_q[i]) : -1;
        break;
      end
    end
    if (bad >= 0) $display("stream differs at byte %0d", bad);
    check("stream", bad < 0, ga, ge);
    check("done_pulse", ndone == 1 && v_done == 0, ndone + v_done, 1);
    check("busy_level", v_busy == 0, v_busy, 0);
    check("valid_outside_readout", v_early == 0, v_early, 0);
    check("stall_hold", v_stall == 0, v_stall, 0);
    check("first_valid_latency", fv > lastw && fv <= lastw + 4,
          fv - lastw, 4);
    if (rdy >= 100) check("throughput", dc - fv == NB - 1, dc - fv, NB - 1);
    @(negedge clk);
    #1;
    check("idle_after_done", !busy && !tx_valid,
          int'({busy, tx_valid}), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    adc_in = '0;
    trig_in = 1'b0;
    arm = 1'b0;
    tx_ready = 1'b0;
    rows[0] = '{10, 100, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 8'h0};
    rows[1] = '{2, 100, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 8'h0};
    rows[2] = '{10, 30, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 8'h0};
    rows[3] = '{3, 100, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 14'h3FFF, 8'h3F, 8'hFF};
    rows[4] = '{5, 60, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 14'h0000, 8'h00, 8'h00};
    rows[5] = '{12, 100, 1'b0, 2, 3, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 8'h0};
    rows[6] = '{8, 100, 1'b1, 3, 8, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 8'h0};

    #12;
    check("rst_busy", busy === 1'b0, int'(busy), 0);
    check("rst_tx_valid", tx_valid === 1'b0, int'(tx_valid), 0);
    check("rst_done", done === 1'b0, int'(done), 0);
    check("rst_tx_data", tx_data === 8'h00, int'(tx_data), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_capture(rows[i].d, rows[i].rdy, rows[i].rnd, rows[i].pf,
                  rows[i].pt, rows[i].pp, rows[i].ax, rows[i].frc,
                  rows[i].tv, 0);
      if (rows[i].frc) begin
        check("trig_hi_byte", act.size() > 10 && act[9] === rows[i].eh,
              (act.size() > 10) ? int'(act[9]) : -1, int'(rows[i].eh));
        check("trig_lo_byte", act.size() > 10 && act[10] === rows[i].el,
              (act.size() > 10) ? int'(act[10]) : -1, int'(rows[i].el));
      end
      if (i == 0) ref0 = act;
      if (i == 2) begin
        int nd;
        nd = (act.size() == ref0.size()) ? 0 : 1;
        for (int k = 0; k < act.size() && k < ref0.size(); k++)
          if (act[k] !== ref0[k]) nd++;
        check("stalled_stream_vs_ref", nd == 0, nd, 0);
      end
    end

    run_capture(10, 100, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 14'h0, 7);
    #2 rst_n = 1'b0;
    #1;
    check("midread_rst_tx_valid", tx_valid === 1'b0, int'(tx_valid), 0);
    check("midread_rst_busy", busy === 1'b0, int'(busy), 0);
    check("midread_rst_done", done === 1'b0, int'(done), 0);
    check("midread_rst_tx_data", tx_data === 8'h00, int'(tx_data), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_capture(6, 100, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 14'h0, 0);

    for (int r = 0; r < 4; r++) begin
      run_capture(int'($urandom_range(0, 20)), int'($urandom_range(25, 100)),
                  1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 14'h0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
